wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 NREQ, 3, number of write-back requesters (0 ALU, 1 LSU, 2 NIC); fixed at 3.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous reset, active-low: state clears on a rising clk edge while reset==0.
REQ-004 req_valid  input  3  per-requester write request.
REQ-005 req_ready  output  3  per-requester grant; a transfer occurs when valid and ready are both 1.
REQ-006 req_addr  input  3x5  destination register per requester.
REQ-007 req_data  input  3x64  write data per requester.
REQ-008 req_ppp  input  3x3  partial-write select per requester (000 full, 001 high word, 010 low word, 011 even bytes, 100 odd bytes).
REQ-009 wb_hold  input  1  pipeline hold; no grants while 1.
REQ-010 issue_valid, issue_addr  input  1, 5  decode marks a destination register pending.
REQ-011 rf_we, rf_addr, rf_data, rf_ppp  output  1, 5, 64, 3  registered register-file write port.
REQ-012 busy_mask  output  32  pending-write scoreboard, bit i = register i.
REQ-013 ppp_err  output  1  one-cycle pulse for an illegal ppp.

Function
REQ-014 Grant at most one requester per cycle, combinationally from req_valid, wb_hold and rr_ptr.
REQ-015 Round-robin: search starts at rr_ptr+1 mod 3; after a transfer, rr_ptr = granted index; rr_ptr holds when no transfer.
REQ-016 wb_hold==1 forces req_ready=000; rr_ptr and busy_mask set/clear from writes are unaffected except no new writes occur.
REQ-017 Latency: a transfer in cycle N drives rf_* in cycle N+1 for exactly one cycle; rf_we=0 otherwise.
REQ-018 Writes with addr 0 are accepted (ready=1) but drive rf_we=0.
REQ-019 ppp values 101-111 are accepted, drive rf_we=0, and pulse ppp_err in cycle N+1.
REQ-020 Scoreboard: issue_valid sets busy_mask[issue_addr] next cycle; a transfer with addr!=0 clears busy_mask[addr] next cycle, including illegal-ppp transfers.
REQ-021 Simultaneous set and clear of the same register in one cycle: set wins (bit = 1).
REQ-022 issue_addr==0 never sets a bit; busy_mask[0] is always 0.
REQ-023 A requester's ready may assert only in a cycle its valid is 1; no speculative grants.

Reset
REQ-024 During reset: req_ready=000, rf_we=0, rf_addr=0, rf_data=0, rf_ppp=000, busy_mask=0, ppp_err=0, rr_ptr=2 (so requester 0 wins first).
REQ-025 Reset mid-transfer discards the in-flight write; rf_we is 0 in the cycle after the reset edge.

Configuration
REQ-026 WB_PERF_CNT_EN defined: three 16-bit saturating counters (output conflict_cnt, 3x16) increment when that requester has valid=1 and ready=0; they clear on reset and hold at 0xFFFF.
REQ-027 WB_PERF_CNT_EN undefined: no counters and no conflict_cnt port; all other behaviour is identical.

Structure
REQ-028 A shared package holds NREQ, the requester index constants, the ppp encodings, and PPP_MAX=100.
REQ-029 A single sub-module, rr_arbiter3 (pointer in, request vector in, one-hot grant out), is combinational; wb_arbiter owns rr_ptr.

Verification
REQ-030 Reset, then valid=111 held for 6 cycles -> grants 0,1,2,0,1,2; rf_we=1 every cycle from cycle 2.
REQ-031 Single requester 1, addr 7, data 0x0123456789ABCDEF, ppp 001 -> next cycle rf_we=1, rf_addr=7, rf_ppp=001, data matches.
REQ-032 issue addr 5, then LSU writes addr 5; same-cycle issue 5 and ALU write 5 -> bit 5 clears, then stays 1 after the collision.
REQ-033 Write addr 0 and write ppp 110 -> ready=1, rf_we=0, ppp_err pulses only for the ppp 110 write.
REQ-034 wb_hold=1 for 3 cycles with valid=111 -> ready=000 and rr_ptr unchanged; WB_PERF_CNT_EN build shows each counter =3.
REQ-035 Assert reset the cycle after a grant -> rf_we=0 next cycle; busy_mask=0; first grant after release goes to requester 0.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the write-back arbiter: requester indices,
// partial-write (ppp) encodings and field widths.
package wb_arbiter_pkg;

    localparam int unsigned NREQ   = 3;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned PPP_W  = 3;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned NREG   = 32;

    // Requester indices
    localparam logic [1:0] REQ_ALU = 2'd0;
    localparam logic [1:0] REQ_LSU = 2'd1;
    localparam logic [1:0] REQ_NIC = 2'd2;

    // Partial-write select encodings
    typedef enum logic [PPP_W-1:0] {
        PPP_FULL = 3'b000,
        PPP_HI   = 3'b001,
        PPP_LO   = 3'b010,
        PPP_EVEN = 3'b011,
        PPP_ODD  = 3'b100
    } ppp_t;

    // Largest legal encoding; anything above is rejected
    localparam logic [PPP_W-1:0] PPP_MAX = 3'b100;

    function automatic logic ppp_legal(input logic [PPP_W-1:0] ppp);
        return ppp <= PPP_MAX;
    endfunction

    // One-hot grant to requester index (no bit set maps to 0)
    function automatic logic [1:0] onehot3_to_idx(input logic [NREQ-1:0] g);
        if (g[2])      return REQ_NIC;
        else if (g[1]) return REQ_LSU;
        else           return REQ_ALU;
    endfunction

endpackage

// File: rtl/wb_arbiter_rr.sv
// rr_arbiter3: combinational three-way round-robin picker.
// The search starts at ptr+1 mod 3; the grant is one-hot or zero.
module rr_arbiter3
    import wb_arbiter_pkg::*;
(
    input  logic [1:0]      ptr,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant
);

    // First requesting index in order a, b, c
    function automatic logic [NREQ-1:0] pick(input logic [NREQ-1:0] r,
                                             input logic [1:0] a,
                                             input logic [1:0] b,
                                             input logic [1:0] c);
        logic [NREQ-1:0] g;
        g = '0;
        if (r[a])      g[a] = 1'b1;
        else if (r[b]) g[b] = 1'b1;
        else if (r[c]) g[c] = 1'b1;
        return g;
    endfunction

    // Priority rotates with the pointer of the last winner
    always_comb begin
        grant = '0;
        case (ptr)
            2'd0:    grant = pick(req, 2'd1, 2'd2, 2'd0);
            2'd1:    grant = pick(req, 2'd2, 2'd0, 2'd1);
            default: grant = pick(req, 2'd0, 2'd1, 2'd2);
        endcase
    end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin write-back arbiter for ALU/LSU/NIC with a
// registered register-file write port and a pending-write scoreboard.
// Optional macro WB_PERF_CNT_EN adds per-requester conflict counters.
module wb_arbiter
    import wb_arbiter_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NREQ-1:0]              req_valid,
    output logic [NREQ-1:0]              req_ready,
    input  logic [NREQ-1:0][ADDR_W-1:0]  req_addr,
    input  logic [NREQ-1:0][DATA_W-1:0]  req_data,
    input  logic [NREQ-1:0][PPP_W-1:0]   req_ppp,
    input  logic                         wb_hold,
    input  logic                         issue_valid,
    input  logic [ADDR_W-1:0]            issue_addr,
    output logic                         rf_we,
    output logic [ADDR_W-1:0]            rf_addr,
    output logic [DATA_W-1:0]            rf_data,
    output logic [PPP_W-1:0]             rf_ppp,
    output logic [NREG-1:0]              busy_mask,
    output logic                         ppp_err
`ifdef WB_PERF_CNT_EN
   ,output logic [NREQ-1:0][CNT_W-1:0]   conflict_cnt
`endif
);

    logic [1:0]        rr_ptr;
    logic [NREQ-1:0]   grant;
    logic              xfer;
    logic [1:0]        gidx;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic [PPP_W-1:0]  sel_ppp;
    logic [NREG-1:0]   busy_nxt;

    rr_arbiter3 u_rr (
        .ptr   (rr_ptr),
        .req   (req_valid),
        .grant (grant)
    );

    // Grants are suppressed while held or in reset
    always_comb begin
        req_ready = '0;
        if (reset && !wb_hold) req_ready = grant;
        xfer = |req_ready;
        gidx = onehot3_to_idx(req_ready);
    end

    // Mux the winning requester's fields
    always_comb begin
        sel_addr = req_addr[0];
        sel_data = req_data[0];
        sel_ppp  = req_ppp[0];
        case (gidx)
            REQ_LSU: begin
                sel_addr = req_addr[1];
                sel_data = req_data[1];
                sel_ppp  = req_ppp[1];
            end
            REQ_NIC: begin
                sel_addr = req_addr[2];
                sel_data = req_data[2];
                sel_ppp  = req_ppp[2];
            end
            default: ;
        endcase
    end

    // Scoreboard next state: clear first so a same-cycle issue wins
    always_comb begin
        busy_nxt = busy_mask;
        if (xfer && sel_addr != '0) busy_nxt[sel_addr] = 1'b0;
        if (issue_valid && issue_addr != '0) busy_nxt[issue_addr] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    // Pointer, write port, error pulse and scoreboard registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr    <= REQ_NIC;
            rf_we     <= 1'b0;
            rf_addr   <= '0;
            rf_data   <= '0;
            rf_ppp    <= '0;
            ppp_err   <= 1'b0;
            busy_mask <= '0;
        end else begin
            rf_we     <= xfer && (sel_addr != '0) && ppp_legal(sel_ppp);
            ppp_err   <= xfer && !ppp_legal(sel_ppp);
            busy_mask <= busy_nxt;
            if (xfer) begin
                rr_ptr  <= gidx;
                rf_addr <= sel_addr;
                rf_data <= sel_data;
                rf_ppp  <= sel_ppp;
            end
        end
    end

`ifdef WB_PERF_CNT_EN
    for (genvar g = 0; g < NREQ; g++) begin : g_cnt
        // Saturating count of cycles requester g waited
        always_ff @(posedge clk) begin
            if (!reset) begin
                conflict_cnt[g] <= '0;
            end else if (req_valid[g] && !req_ready[g] && conflict_cnt[g] != '1) begin
                conflict_cnt[g] <= conflict_cnt[g] + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: vector table for arbitration and
// latency, plus directed sequences for scoreboard, errors, hold and reset.
module tb_wb_arbiter;

    logic             clk = 1'b0;
    logic             reset;
    logic [2:0]       req_valid;
    logic [2:0]       req_ready;
    logic [2:0][4:0]  req_addr;
    logic [2:0][63:0] req_data;
    logic [2:0][2:0]  req_ppp;
    logic             wb_hold;
    logic             issue_valid;
    logic [4:0]       issue_addr;
    logic             rf_we;
    logic [4:0]       rf_addr;
    logic [63:0]      rf_data;
    logic [2:0]       rf_ppp;
    logic [31:0]      busy_mask;
    logic             ppp_err;
`ifdef WB_PERF_CNT_EN
    logic [2:0][15:0] conflict_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_ppp     (req_ppp),
        .wb_hold     (wb_hold),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .rf_we       (rf_we),
        .rf_addr     (rf_addr),
        .rf_data     (rf_data),
        .rf_ppp      (rf_ppp),
        .busy_mask   (busy_mask),
        .ppp_err     (ppp_err)
`ifdef WB_PERF_CNT_EN
       ,.conflict_cnt(conflict_cnt)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Advance one edge and land 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0] valid;
        logic       hold;
        logic [2:0] exp_ready;
        logic       exp_we;
        logic [4:0] exp_addr;
    } vec_t;

    vec_t tbl [14];

    localparam logic [63:0] D0 = 64'h1111_0000_AAAA_0000;
    localparam logic [63:0] D1 = 64'h2222_0000_BBBB_0001;
    localparam logic [63:0] D2 = 64'h3333_0000_CCCC_0002;

    logic [63:0] exp_data;

    initial begin
        // Round-robin walk starting with rr_ptr=2 after reset
        tbl[0]  = '{3'b111, 1'b0, 3'b001, 1'b1, 5'd1};
        tbl[1]  = '{3'b111, 1'b0, 3'b010, 1'b1, 5'd2};
        tbl[2]  = '{3'b111, 1'b0, 3'b100, 1'b1, 5'd3};
        tbl[3]  = '{3'b111, 1'b0, 3'b001, 1'b1, 5'd1};
        tbl[4]  = '{3'b111, 1'b0, 3'b010, 1'b1, 5'd2};
        tbl[5]  = '{3'b111, 1'b0, 3'b100, 1'b1, 5'd3};
        tbl[6]  = '{3'b010, 1'b0, 3'b010, 1'b1, 5'd2};
        tbl[7]  = '{3'b010, 1'b0, 3'b010, 1'b1, 5'd2};
        tbl[8]  = '{3'b101, 1'b0, 3'b100, 1'b1, 5'd3};
        tbl[9]  = '{3'b101, 1'b0, 3'b001, 1'b1, 5'd1};
        tbl[10] = '{3'b111, 1'b1, 3'b000, 1'b0, 5'd0};
        tbl[11] = '{3'b000, 1'b0, 3'b000, 1'b0, 5'd0};
        tbl[12] = '{3'b110, 1'b0, 3'b010, 1'b1, 5'd2};
        tbl[13] = '{3'b011, 1'b0, 3'b001, 1'b1, 5'd1};

        reset       = 1'b0;
        req_valid   = 3'b111;
        req_addr[0] = 5'd1;
        req_addr[1] = 5'd2;
        req_addr[2] = 5'd3;
        req_data[0] = D0;
        req_data[1] = D1;
        req_data[2] = D2;
        req_ppp     = '0;
        wb_hold     = 1'b0;
        issue_valid = 1'b0;
        issue_addr  = '0;

        // Reset state, with requests present
        tick();
        tick();
        chk("rst_ready", req_ready, 3'b000);
        chk("rst_we", rf_we, 1'b0);
        chk("rst_addr", rf_addr, 5'd0);
        chk("rst_data", rf_data, 64'd0);
        chk("rst_ppp", rf_ppp, 3'd0);
        chk("rst_busy", busy_mask, 32'd0);
        chk("rst_err", ppp_err, 1'b0);
        reset = 1'b1;

        // Table walk
        for (int i = 0; i < 14; i++) begin
            req_valid = tbl[i].valid;
            wb_hold   = tbl[i].hold;
            #1;
            chk($sformatf("tbl%0d_ready", i), req_ready, tbl[i].exp_ready);
            case (tbl[i].exp_ready)
                3'b010:  exp_data = D1;
                3'b100:  exp_data = D2;
                default: exp_data = D0;
            endcase
            tick();
            chk($sformatf("tbl%0d_we", i), rf_we, tbl[i].exp_we);
            chk($sformatf("tbl%0d_err", i), ppp_err, 1'b0);
            if (tbl[i].exp_we) begin
                chk($sformatf("tbl%0d_addr", i), rf_addr, tbl[i].exp_addr);
                chk($sformatf("tbl%0d_data", i), rf_data, exp_data);
            end
        end
        wb_hold = 1'b0;

        // Single LSU write with high-word select (ptr 0 -> LSU first)
        req_valid   = 3'b010;
        req_addr[1] = 5'd7;
        req_data[1] = 64'h0123_4567_89AB_CDEF;
        req_ppp[1]  = 3'b001;
        #1;
        chk("lsu_ready", req_ready, 3'b010);
        tick();
        chk("lsu_we", rf_we, 1'b1);
        chk("lsu_addr", rf_addr, 5'd7);
        chk("lsu_ppp", rf_ppp, 3'b001);
        chk("lsu_data", rf_data, 64'h0123_4567_89AB_CDEF);
        req_valid  = 3'b000;
        req_ppp[1] = 3'b000;
        tick();
        chk("lsu_we_once", rf_we, 1'b0);

        // Scoreboard: issue 5, clear by LSU, then collision where set wins
        issue_valid = 1'b1;
        issue_addr  = 5'd5;
        tick();
        chk("sb_set5", busy_mask, 32'h0000_0020);
        issue_valid = 1'b0;
        req_valid   = 3'b010;
        req_addr[1] = 5'd5;
        tick();
        chk("sb_clr5", busy_mask, 32'h0000_0000);
        req_valid   = 3'b001;
        req_addr[0] = 5'd5;
        issue_valid = 1'b1;
        #1;
        chk("sb_col_ready", req_ready, 3'b001);
        tick();
        chk("sb_collide", busy_mask, 32'h0000_0020);
        req_valid  = 3'b000;
        issue_addr = 5'd0;
        tick();
        chk("sb_issue0", busy_mask, 32'h0000_0020);

        // Address-0 write and illegal-ppp write
        issue_addr  = 5'd9;
        tick();
        chk("sb_set9", busy_mask, 32'h0000_0220);
        issue_valid = 1'b0;
        req_valid   = 3'b001;
        req_addr[0] = 5'd0;
        #1;
        chk("a0_ready", req_ready, 3'b001);
        tick();
        chk("a0_we", rf_we, 1'b0);
        chk("a0_err", ppp_err, 1'b0);
        req_addr[0] = 5'd9;
        req_ppp[0]  = 3'b110;
        #1;
        chk("bad_ready", req_ready, 3'b001);
        tick();
        chk("bad_we", rf_we, 1'b0);
        chk("bad_err", ppp_err, 1'b1);
        chk("bad_clr9", busy_mask, 32'h0000_0020);
        req_valid  = 3'b000;
        req_ppp[0] = 3'b000;
        tick();
        chk("bad_err_pulse", ppp_err, 1'b0);

        // Hold for three cycles right after reset
        reset = 1'b0;
        tick();
        reset       = 1'b1;
        req_addr[0] = 5'd1;
        req_addr[1] = 5'd2;
        req_addr[2] = 5'd3;
        req_valid   = 3'b111;
        wb_hold     = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("hold%0d_ready", c), req_ready, 3'b000);
            tick();
            chk($sformatf("hold%0d_we", c), rf_we, 1'b0);
        end
`ifdef WB_PERF_CNT_EN
        chk("cnt0", conflict_cnt[0], 16'd3);
        chk("cnt1", conflict_cnt[1], 16'd3);
        chk("cnt2", conflict_cnt[2], 16'd3);
`endif
        wb_hold = 1'b0;
        #1;
        chk("hold_ptr_kept", req_ready, 3'b001);
        tick();

        // Reset the cycle after a grant: write discarded
        req_valid   = 3'b010;
        issue_valid = 1'b1;
        issue_addr  = 5'd4;
        #1;
        chk("mid_ready", req_ready, 3'b010);
        tick();
        reset       = 1'b0;
        issue_valid = 1'b0;
        #1;
        chk("mid_rst_ready", req_ready, 3'b000);
        tick();
        chk("mid_we", rf_we, 1'b0);
        chk("mid_busy", busy_mask, 32'd0);
        chk("mid_addr", rf_addr, 5'd0);
        reset     = 1'b1;
        req_valid = 3'b111;
        #1;
        chk("post_rst_first", req_ready, 3'b001);
        tick();
        chk("post_rst_we", rf_we, 1'b1);
        chk("post_rst_addr", rf_addr, 5'd1);
        req_valid = 3'b000;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
